// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared types and helpers for the four-way round-robin output-channel arbiter.
// Imported by the arbiter top and by the rotating priority picker.
package rr_mux4_arbiter_pkg;

  localparam int NREQ = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage : rr_mux4_arbiter_pkg

// File: rtl/rr_mux4_arbiter_pick4.sv
// Rotating priority search: first set req bit starting just after 'last',
// wrapping round so that 'last' itself has the lowest priority.
module rr_pick4
  import rr_mux4_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic            any,
  output logic [1:0]      idx
);

  logic [1:0] cand;

  // Walk from lowest to highest priority so the last hit seen is the winner.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    any  = 1'b0;
    idx  = 2'd0;
    cand = 2'd0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = last + 2'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule : rr_pick4

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter sharing one 4:1 output channel between four requesters,
// granting one burst at a time with a beat limit and a valid/ready handshake.
module rr_mux4_arbiter
  import rr_mux4_arbiter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       sel,
  output logic [3:0]       grant,
  output logic             busy
);

  localparam int                CNT_W     = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_BEATS - 1);

  state_t            state_q, state_d;
  logic [3:0]        grant_q, grant_d;
  logic [1:0]        sel_q,   sel_d;
  logic [1:0]        last_q,  last_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              pick_any;
  logic [1:0]        pick_idx;
  logic              xfer;

  rr_pick4 u_pick (
    .req  (req),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign busy      = (state_q == ST_GRANT);
  assign out_valid = busy & req[sel_q];
  assign xfer      = out_valid & out_ready;
  assign in_ready  = grant_q & {4{out_ready}};
  assign grant     = grant_q;
  assign sel       = sel_q;

  always_comb begin
    unique case (sel_q)
      2'd0:    out_data = d0;
      2'd1:    out_data = d1;
      2'd2:    out_data = d2;
      default: out_data = d3;
    endcase
  end

  // Next-state logic. A new request arriving on a release edge is not looked at
  // until the following IDLE cycle, which guarantees the one-cycle gap.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = last_q;
    count_d = count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_GRANT;
          grant_d = onehot4(pick_idx);
          sel_d   = pick_idx;
          count_d = '0;
        end
      end
      ST_GRANT: begin
        if (!req[sel_q] || (xfer && count_q == LAST_BEAT)) begin
          state_d = ST_IDLE;
          grant_d = 4'b0000;
          last_d  = sel_q;
        end else if (xfer) begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values; the reset is synchronous, so it lives inside the clocked branch.
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= 4'b0000;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

endmodule : rr_mux4_arbiter

// File: tb/tb_rr_mux4_arbiter.sv
// Self-checking bench: directed scenarios then random traffic, checked against a
// burst-level reference model and a scoreboard of expected transfers.
module tb_rr_mux4_arbiter;

  localparam int WIDTH     = 8;
  localparam int MAX_BEATS = 4;

  bit               clk;
  logic             rst;
  logic [3:0]       req;
  logic [WIDTH-1:0] d [4];
  logic             out_ready;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       sel;
  logic [3:0]       grant;
  logic             busy;

  rr_mux4_arbiter #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .d0        (d[0]),
    .d1        (d[1]),
    .d2        (d[2]),
    .d3        (d[3]),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel       (sel),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: who owns the channel (-1 = nobody), beats delivered in
  // this burst, the requester most recently released, and the held select.
  int owner = -1;
  int beats = 0;
  int last  = 3;
  int msel  = 0;

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      owner = -1; beats = 0; last = 3; msel = 0;
    end else if (owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        if (owner < 0 && req[(last + k) % 4]) begin
          owner = (last + k) % 4;
          msel  = owner;
          beats = 0;
        end
      end
    end else if (!req[owner]) begin
      last  = owner;
      owner = -1;
    end else if (out_ready) begin
      beats++;
      if (beats == MAX_BEATS) begin
        last  = owner;
        owner = -1;
      end
    end
  end

  typedef struct {
    int               idx;
    logic [WIDTH-1:0] data;
  } xfer_t;

  xfer_t exp_q[$];

  // Drive one cycle of stimulus just after the edge and predict any transfer.
  task automatic step(input logic [3:0] r, input logic rdy, input logic rs);
    xfer_t x;
    @(posedge clk);
    #1;
    req       = r;
    out_ready = rdy;
    rst       = rs;
    for (int i = 0; i < 4; i++) d[i] = WIDTH'($urandom);
    if (owner >= 0 && req[owner] && out_ready) begin
      x.idx  = owner;
      x.data = d[owner];
      exp_q.push_back(x);
    end
  endtask

  // Monitor: compare the DUT's presented outputs with the model mid-cycle.
  always @(negedge clk) begin
    xfer_t x;
    logic [3:0] egrant;
    if (started) begin
      egrant = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
      check("grant",     grant,     egrant);
      check("busy",      busy,      owner >= 0);
      check("sel",       sel,       msel);
      check("out_valid", out_valid, owner >= 0 && req[owner]);
      check("in_ready",  in_ready,  egrant & {4{out_ready}});
      check("out_data",  out_data,  d[msel]);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", {30'd0, sel}, 32'hffff_ffff);
        end else begin
          x = exp_q.pop_front();
          check("xfer_idx",  sel,      x.idx);
          check("xfer_data", out_data, x.data);
        end
      end
      if (exp_q.size() != 0) begin
        check("missed_xfer", exp_q.size(), 0);
        exp_q.delete();
      end
    end
  end

  initial begin
    logic [3:0] r;
    rst = 1'b1; req = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) d[i] = '0;

    // Reset with all requesting, then first grant must go to requester 0.
    repeat (2) step(4'b1111, 1'b1, 1'b1);
    repeat (3) step(4'b1111, 1'b1, 1'b0);
    // Sole requester: burst limit, idle gap, re-grant to itself.
    repeat (4)  step(4'b0000, 1'b1, 1'b0);
    repeat (14) step(4'b0100, 1'b1, 1'b0);
    // Fairness with everybody requesting.
    repeat (4)  step(4'b0000, 1'b1, 1'b0);
    repeat (30) step(4'b1111, 1'b1, 1'b0);
    // Backpressure on requester 1.
    repeat (3)  step(4'b0000, 1'b1, 1'b0);
    repeat (2)  step(4'b0010, 1'b1, 1'b0);
    repeat (5)  step(4'b0010, 1'b0, 1'b0);
    repeat (6)  step(4'b0010, 1'b1, 1'b0);
    // Withdrawal of requester 0 after one beat.
    repeat (3)  step(4'b0000, 1'b1, 1'b0);
    repeat (2)  step(4'b0001, 1'b1, 1'b0);
    repeat (5)  step(4'b0110, 1'b1, 1'b0);
    // Reset in the middle of a burst from requester 3.
    repeat (3)  step(4'b0000, 1'b1, 1'b0);
    repeat (2)  step(4'b1000, 1'b1, 1'b0);
    step(4'b1000, 1'b1, 1'b1);
    repeat (4)  step(4'b1001, 1'b1, 1'b0);

    // Random traffic with sticky requests, random backpressure and rare resets.
    r = 4'b0000;
    repeat (3000) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(5) == 0) r[i] = ~r[i];
      step(r, $urandom_range(3) != 0, $urandom_range(63) == 0);
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_rr_mux4_arbiter
